wb_arbiter: RTL

Parametrised write-back arbiter that merges results from N_SRC producer channels (ALU, load, CSR, multi-cycle units) into N_WPORT register-file write ports. Each channel has a small FIFO with valid/ready handshake, so producers with different latencies retire without stalling each other. Grants are round-robin and never write the same destination twice in one cycle. The block sits between the memory/exec stages and the register file in the decode stage, replacing the single-source result mux.

---
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-channel result FIFOs merged onto N_WPORT register-file
// write ports. Round-robin grant, never two writes to the same nonzero rd
// in one cycle, per-channel order preserved.
module wb_arbiter #(
  parameter int N_SRC   = 4,
  parameter int DEPTH   = 4,
  parameter int N_WPORT = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*5-1:0]      src_rd,
  input  logic [N_SRC*XLEN-1:0]   src_data,
  output logic [N_WPORT-1:0]      reg_write_w,
  output logic [N_WPORT*5-1:0]    rd_w,
  output logic [N_WPORT*XLEN-1:0] result_w,
  output logic [N_SRC-1:0]        pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(N_SRC);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]      mem_rd   [N_SRC][DEPTH];
  logic [XLEN-1:0] mem_data [N_SRC][DEPTH];
  logic [AW-1:0]   wr_ptr   [N_SRC];
  logic [AW-1:0]   rd_ptr   [N_SRC];
  logic [AW:0]     count    [N_SRC];
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   rr_next;

  logic [N_SRC-1:0]   push;
  logic [N_SRC-1:0]   grant;
  logic [N_WPORT-1:0] port_valid;
  logic [4:0]         port_rd   [N_WPORT];
  logic [XLEN-1:0]    port_data [N_WPORT];

  int unsigned n_grant;
  int unsigned idx;
  int unsigned last_idx;
  logic        conflict;
  logic        any_grant;
  logic [4:0]  head_rd;

  // Channel status derived from registered occupancy only
  always_comb begin
    src_ready = '0;
    pending   = '0;
    push      = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count[i] != FULL);
      pending[i]   = (count[i] != '0);
      push[i]      = src_valid[i] && (count[i] != FULL);
    end
  end

  // Round-robin search from rr_ptr; fill ports in search order, skipping
  // heads whose nonzero rd is already granted this cycle
  always_comb begin
    grant      = '0;
    port_valid = '0;
    for (int unsigned p = 0; p < N_WPORT; p++) begin
      port_rd[p]   = '0;
      port_data[p] = '0;
    end
    n_grant   = 0;
    last_idx  = 0;
    any_grant = 1'b0;
    idx       = 0;
    conflict  = 1'b0;
    head_rd   = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      head_rd  = mem_rd[idx][rd_ptr[idx]];
      conflict = 1'b0;
      for (int unsigned p = 0; p < N_WPORT; p++) begin
        if (p < n_grant && head_rd != 5'd0 && port_rd[p] == head_rd) conflict = 1'b1;
      end
      if (count[idx] != '0 && n_grant < N_WPORT && !conflict) begin
        grant[idx]          = 1'b1;
        port_valid[n_grant] = 1'b1;
        port_rd[n_grant]    = head_rd;
        port_data[n_grant]  = mem_data[idx][rd_ptr[idx]];
        n_grant             = n_grant + 1;
        last_idx            = idx;
        any_grant           = 1'b1;
      end
    end
    rr_next = rr_ptr;
    if (any_grant) rr_next = (last_idx + 1 == N_SRC) ? '0 : SW'(last_idx + 1);
  end

  // FIFO pointers, occupancy and round-robin pointer; flush keeps rr_ptr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !grant[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && grant[i]) count[i] <= count[i] - 1'b1;
      end
      rr_ptr <= rr_next;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (push[i] && !flush) begin
        mem_rd[i][wr_ptr[i]]   <= src_rd[i*5 +: 5];
        mem_data[i][wr_ptr[i]] <= src_data[i*XLEN +: XLEN];
      end
    end
  end

  // Registered write ports; rd_w/result_w hold when a port is not granted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_write_w <= '0;
      rd_w        <= '0;
      result_w    <= '0;
    end else if (flush) begin
      reg_write_w <= '0;
    end else begin
      for (int unsigned p = 0; p < N_WPORT; p++) begin
        reg_write_w[p] <= port_valid[p] && (port_rd[p] != 5'd0);
        if (port_valid[p]) begin
          rd_w[p*5 +: 5]           <= port_rd[p];
          result_w[p*XLEN +: XLEN] <= port_data[p];
        end
      end
    end
  end

endmodule
